rv_program_loader: RTL and testbench

- Byte-stream boot loader upstream of the RISCV32 core.
- Receives a framed program image and assembles little-endian 32-bit words. Writes them into instruction/data memory through a single write port.
- Holds the core in reset until a complete, checksum-verified image has been written.
- Replaces hierarchical memory preloading for system-level boot and testing.

---
 rtl/rv_program_loader.sv | 135 +++++++++++++
 tb/tb_rv_program_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_program_loader.sv
// Byte-stream boot loader: parses a framed image, writes little-endian words
// into memory and releases the core from reset once the checksum matches.
module rv_program_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0]       MAX_N = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [7:0]  cnt_lo;
  logic [7:0]  csum_acc;
  logic [15:0] n_words;
  logic [1:0]  byte_idx;
  logic [23:0] asm_p0;
  logic        accept;
  logic [15:0] hdr_n;
  logic [15:0] wl_next;

  assign accept  = s_valid && s_ready;
  assign hdr_n   = {s_data, cnt_lo};
  assign wl_next = words_loaded + 16'd1;

  // Address arithmetic wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] idx);
    return BASE + idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HDR0;
      s_ready      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      csum_acc     <= '0;
      byte_idx     <= '0;
      cnt_lo       <= '0;
      n_words      <= '0;
      asm_p0       <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR0: begin
          s_ready <= 1'b1;
          if (accept) begin
            cnt_lo   <= s_data;
            csum_acc <= csum_acc ^ s_data;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            csum_acc <= csum_acc ^ s_data;
            n_words  <= hdr_n;
            if ({1'b0, hdr_n} > MAX_N) begin
              state    <= ERR;
              s_ready  <= 1'b0;
              load_err <= 1'b1;
            end else if (hdr_n == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum_acc <= csum_acc ^ s_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Write stage: the completed word is presented one cycle after its last byte.
              mem_we       <= 1'b1;
              mem_addr     <= wrap_addr(words_loaded[ADDR_W-1:0]);
              mem_wdata    <= {s_data, asm_p0};
              words_loaded <= wl_next;
              if (wl_next == n_words) state <= CSUM;
            end else begin
              asm_p0 <= {s_data, asm_p0[23:8]};
            end
          end
        end
        CSUM: begin
          if (accept) begin
            s_ready <= 1'b0;
            if (s_data == csum_acc) begin
              state      <= DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (reload) begin
            state        <= HDR0;
            s_ready      <= 1'b1;
            core_rst_n   <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            csum_acc     <= '0;
            byte_idx     <= '0;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_program_loader.sv
// Bench for rv_program_loader: two instances (base 0 and base 1022) share one
// byte stream; writes and flags are compared against a frame-parsing model.
module tb_rv_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        reload = 1'b0;

  logic        s_ready0, mem_we0, core_rst_n0, load_done0, load_err0;
  logic [9:0]  mem_addr0;
  logic [31:0] mem_wdata0;
  logic [15:0] words_loaded0;
  logic        s_ready1, mem_we1, core_rst_n1, load_done1, load_err1;
  logic [9:0]  mem_addr1;
  logic [31:0] mem_wdata1;
  logic [15:0] words_loaded1;

  rv_program_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
    .reload(reload), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .core_rst_n(core_rst_n0), .load_done(load_done0), .load_err(load_err0),
    .words_loaded(words_loaded0));

  rv_program_loader #(.ADDR_W(10), .BASE_ADDR(1022), .MAX_WORDS(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
    .reload(reload), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .core_rst_n(core_rst_n1), .load_done(load_done1), .load_err(load_err1),
    .words_loaded(words_loaded1));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  frame[$];
  logic [41:0] q0[$];
  logic [41:0] q1[$];
  logic [41:0] exp0[$];
  logic [41:0] exp1[$];
  logic        exp_done, exp_err;
  int          exp_words, n_accept;

  always @(negedge clk) begin
    if (mem_we0) q0.push_back({mem_addr0, mem_wdata0});
    if (mem_we1) q1.push_back({mem_addr1, mem_wdata1});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: parse the frame as a list of bytes and derive what must happen.
  task automatic model();
    int n;
    logic [7:0] acc;
    logic [31:0] w;
    exp0.delete(); exp1.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_words = 0;
    n = {frame[1], frame[0]};
    acc = frame[0] ^ frame[1];
    if (n > 1024) begin
      exp_err = 1'b1;
      n_accept = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        w = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
        acc = acc ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        exp0.push_back({10'(i % 1024), w});
        exp1.push_back({10'((1022 + i) % 1024), w});
      end
      exp_words = n;
      n_accept = 3 + 4 * n;
      exp_done = (frame[2+4*n] == acc);
      exp_err = !exp_done;
    end
  endtask

  task automatic make_frame(input int n, input bit corrupt);
    logic [7:0] acc, b;
    frame.delete();
    frame.push_back(8'(n)); frame.push_back(8'(n >> 8));
    acc = frame[0] ^ frame[1];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      acc ^= b;
    end
    if (corrupt) acc ^= 8'($urandom_range(1, 255));
    frame.push_back(acc);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit must);
    int t = 0;
    s_valid = 1'b1; s_data = b;
    if (must) begin
      while (!s_ready0 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 50) begin
        checks++; fails++;
        $display("FAIL ready_timeout: s_ready stayed 0 for %0d cycles, required 1", t);
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int reload_at);
    q0.delete(); q1.delete();
    model();
    for (int i = 0; i < frame.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (i == reload_at) begin
        reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
      end
      send_byte(frame[i], i < n_accept);
      if (i == n_accept - 1)
        chk("flag_edge", {load_done0, load_err0, s_ready0}, {exp_done, exp_err, 1'b0});
    end
  endtask

  task automatic check_frame(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_wr0_n"}, q0.size(), exp0.size());
    chk({name, "_wr1_n"}, q1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < q0.size(); i++) chk({name, "_wr0"}, q0[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) chk({name, "_wr1"}, q1[i], exp1[i]);
    chk({name, "_flags0"}, {load_done0, load_err0, core_rst_n0, s_ready0},
        {exp_done, exp_err, exp_done, 1'b0});
    chk({name, "_flags1"}, {load_done1, load_err1, core_rst_n1, s_ready1},
        {exp_done, exp_err, exp_done, 1'b0});
    chk({name, "_words0"}, words_loaded0, 16'(exp_words));
    chk({name, "_words1"}, words_loaded1, 16'(exp_words));
  endtask

  task automatic do_reload();
    reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
    chk("reload_state", {s_ready0, load_done0, load_err0, core_rst_n0, words_loaded0},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
  endtask

  task automatic check_reset(input string name);
    chk(name, {s_ready0, mem_we0, mem_addr0, mem_wdata0, core_rst_n0, load_done0, load_err0, words_loaded0},
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    chk({name, "_1"}, {s_ready1, mem_we1, mem_addr1, mem_wdata1, core_rst_n1, words_loaded1},
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 16'd0});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    chk("ready_before_edge", s_ready0, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", s_ready0, 1'b1);

    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h80, 8'h07, 8'h03, 8'h21, 8'h01, 8'h00, 8'h35};
    send_frame(1'b0, -1);
    check_frame("frame1");

    do_reload();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h80, 8'h07, 8'h03, 8'h21, 8'h01, 8'h00, 8'h36};
    send_frame(1'b0, -1);
    check_frame("bad_csum");

    do_reload();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0, -1);
    check_frame("empty");

    do_reload();
    frame = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(1'b0, -1);
    check_frame("oversize");

    do_reload();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h80, 8'h07, 8'h03, 8'h21, 8'h01, 8'h00, 8'h35};
    send_frame(1'b1, -1);
    check_frame("gaps");

    do_reload();
    make_frame(3, 1'b0);
    send_frame(1'b1, 4);
    check_frame("wrap");

    do_reload();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h80, 8'h07, 8'h03, 8'h21, 8'h01, 8'h00, 8'h35};
    for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("midframe_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0, -1);
    check_frame("after_reset");

    for (int k = 0; k < 8; k++) begin
      do_reload();
      make_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0);
      send_frame(1'b1, -1);
      check_frame("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
